// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared sizes, entry layout and helpers for the posted-write
// store buffer (store_buffer) and its load-match unit (sb_match).
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    // One buffered store; address is held at word granularity.
    typedef struct packed {
        logic              valid;
        logic [SB_AW-1:2]  addr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

    // Pointer width for a buffer of n entries (n is a power of two, >= 2).
    function automatic int sb_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Word address of a byte address; loads and stores match on this slice.
    function automatic logic [SB_AW-3:0] sb_word_addr(input logic [SB_AW-1:0] byte_addr);
        return byte_addr[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/sb_match.sv
// sb_match: compares a load word address against every buffered store and
// returns the youngest matching entry (closest to the write pointer).
// Only entries within [rd_ptr, rd_ptr+count) that are marked valid can match.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int WAW   = SB_AW - 2,
    parameter int DW    = SB_DW,
    parameter int PW    = sb_clog2(SB_DEPTH)
) (
    input  logic [DEPTH-1:0]     valid,
    input  logic [DEPTH*WAW-1:0] addr_flat,
    input  logic [DEPTH*DW-1:0]  data_flat,
    input  logic [PW-1:0]        rd_ptr,
    input  logic [PW:0]          count,
    input  logic [WAW-1:0]       ld_word,
    output logic                 hit,
    output logic [DW-1:0]        data
);

    logic [DEPTH-1:0] slot_match;
    logic [PW-1:0]    idx;

    // One comparator per physical slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign slot_match[gi] = valid[gi] && (addr_flat[gi*WAW +: WAW] == ld_word);
        end
    endgenerate

    // Walk oldest to youngest so that a younger match overrides an older one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((k < int'(count)) && slot_match[idx]) begin
                hit  = 1'b1;
                data = data_flat[int'(idx)*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data memory.
// Stores are accepted in one cycle and drained in order, one per cycle,
// whenever a load is not using the memory port. Loads are checked against
// pending stores so they never observe stale memory.
// Optional macro STORE_BUF_FWD_EN: forward the youngest matching store to the
// load instead of stalling it.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic          dm_write,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          empty
);

    localparam int          PW         = sb_clog2(DEPTH);
    localparam int          WAW        = AW - 2;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    // Storage and queue state.
    logic [DEPTH-1:0] valid_reg;
    logic [WAW-1:0]   addr_reg [DEPTH];
    logic [DW-1:0]    data_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;

    // Registered memory-port drive.
    logic             dm_write_reg;
    logic [WAW-1:0]   dm_addr_reg;
    logic [DW-1:0]    dm_wdata_reg;

    logic             push;
    logic             pop;

    logic [DEPTH*WAW-1:0] addr_flat;
    logic [DEPTH*DW-1:0]  fwd_flat;
    logic                 match_hit;
    logic [DW-1:0]        match_data;

    // Byte offsets never participate in matching or in the memory address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    // Slot availability depends on registered count only: a same-cycle pop
    // does not open a slot for the incoming store.
    assign st_ready = (count_reg != FULL_COUNT);
    assign push     = st_valid && st_ready;
    assign pop      = (count_reg != '0) && !ld_valid;

    assign dm_write = dm_write_reg;
    assign dm_addr  = {dm_addr_reg, 2'b00};
    assign dm_wdata = dm_wdata_reg;
    assign empty    = (count_reg == '0) && !dm_write_reg;

    // Capture the incoming store into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_reg[wr_ptr_reg] <= st_addr[AW-1:2];
            data_reg[wr_ptr_reg] <= st_data;
        end
    end

    // Per-slot valid bits: set on push, cleared when the slot drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr_reg == PW'(i))) begin
                    valid_reg[i] <= 1'b1;
                end else if (pop && (rd_ptr_reg == PW'(i))) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Present the head entry to memory the cycle after it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_write_reg <= 1'b0;
            dm_addr_reg  <= '0;
            dm_wdata_reg <= '0;
        end else begin
            dm_write_reg <= pop;
            if (pop) begin
                dm_addr_reg  <= addr_reg[rd_ptr_reg];
                dm_wdata_reg <= data_reg[rd_ptr_reg];
            end
        end
    end

    // Flatten slot contents for the match unit. Without forwarding the data
    // path is fed zeros, so the forwarding mux disappears.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign addr_flat[gi*WAW +: WAW] = addr_reg[gi];
`ifdef STORE_BUF_FWD_EN
            assign fwd_flat[gi*DW +: DW] = data_reg[gi];
`else
            assign fwd_flat[gi*DW +: DW] = '0;
`endif
        end
    endgenerate

    sb_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW),
        .DW    (DW),
        .PW    (PW)
    ) u_match (
        .valid     (valid_reg),
        .addr_flat (addr_flat),
        .data_flat (fwd_flat),
        .rd_ptr    (rd_ptr_reg),
        .count     (count_reg),
        .ld_word   (ld_addr[AW-1:2]),
        .hit       (match_hit),
        .data      (match_data)
    );

`ifdef STORE_BUF_FWD_EN
    assign ld_hit   = match_hit;
    assign ld_stall = 1'b0;
`else
    assign ld_hit   = 1'b0;
    assign ld_stall = match_hit;
`endif
    assign ld_data  = match_data;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer with hand-computed
// expectations: reset, mid-traffic reset, fill/full, push+pop wrap,
// load match (forward or stall depending on STORE_BUF_FWD_EN), port conflict.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la);
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_valid = lv;
        ld_addr  = la;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_st_ready", st_ready, 1);
        check("rst_empty",    empty,    1);
        check("rst_dm_write", dm_write, 0);
        check("rst_dm_addr",  dm_addr,  0);
        check("rst_dm_wdata", dm_wdata, 0);
        check("rst_ld_hit",   ld_hit,   0);
        check("rst_ld_data",  ld_data,  0);
        check("rst_ld_stall", ld_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-traffic reset: 3 stores held by a load, one drains, then reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h40 + 32'(4*i), 32'hA0 + 32'(i), 1'b1, 32'h800);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h800);
        #1;
        check("mid_empty_before", empty, 0);
        @(negedge clk);
        #1;
        check("mid_dm_write_before", dm_write, 1);
        check("mid_dm_addr_before",  dm_addr,  32'h40);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty",    empty,    1);
        check("mid_rst_st_ready", st_ready, 1);
        check("mid_rst_dm_write", dm_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid_after_empty",    empty,    1);
        check("mid_after_dm_write", dm_write, 0);

        // Fill: 4 stores with the port held by a load; 5th is refused.
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            drive(1'b1, 32'h10 * 32'(n + 1), 32'h1000 + 32'(n), 1'b1, 32'h800);
        end
        @(negedge clk);
        drive(1'b1, 32'h50, 32'h1004, 1'b1, 32'h800);
        #1;
        check("full_st_ready", st_ready, 0);
        check("full_dm_write", dm_write, 0);
        check("full_empty",    empty,    0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h800);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("fill_dm_write_%0d", k), dm_write, 1);
            check($sformatf("fill_dm_addr_%0d", k),  dm_addr,  32'h10 * 32'(k + 1));
            check($sformatf("fill_dm_wdata_%0d", k), dm_wdata, 32'h1000 + 32'(k));
        end
        check("fill_last_empty", empty, 0);
        @(negedge clk);
        #1;
        check("fill_done_dm_write", dm_write, 0);
        check("fill_done_empty",    empty,    1);

        // Push+pop every cycle: occupancy stays at one, pointers wrap.
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n < 6) begin
                drive(1'b1, 32'h200 + 32'(4*n), 32'h5000 + 32'(n), 1'b0, 32'h800);
            end else begin
                drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h800);
            end
            #1;
            if (n >= 2) begin
                check($sformatf("pp_dm_write_%0d", n), dm_write, 1);
                check($sformatf("pp_dm_addr_%0d", n),  dm_addr,  32'h200 + 32'(4*(n-2)));
                check($sformatf("pp_dm_wdata_%0d", n), dm_wdata, 32'h5000 + 32'(n-2));
            end
            if (n >= 1) begin
                check($sformatf("pp_st_ready_%0d", n), st_ready, 1);
                check($sformatf("pp_empty_%0d", n),    empty,    0);
            end
        end
        @(negedge clk);
        #1;
        check("pp_done_dm_write", dm_write, 0);
        check("pp_done_empty",    empty,    1);

        // Two stores to the same word held behind a load, then a matching load.
        @(negedge clk);
        drive(1'b1, 32'h100, 32'hAAAA, 1'b1, 32'h800);
        @(negedge clk);
        drive(1'b1, 32'h100, 32'hBBBB, 1'b1, 32'h800);
        @(negedge clk);
`ifdef STORE_BUF_FWD_EN
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h102);
        #1;
        check("fwd_ld_hit",   ld_hit,   1);
        check("fwd_ld_data",  ld_data,  32'hBBBB);
        check("fwd_ld_stall", ld_stall, 0);
        check("fwd_dm_write", dm_write, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
        #1;
        check("fwd_miss_ld_hit",  ld_hit,  0);
        check("fwd_miss_ld_data", ld_data, 0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h800);
        @(negedge clk);
        #1;
        check("fwd_drain0_wdata", dm_wdata, 32'hAAAA);
        @(negedge clk);
        #1;
        check("fwd_drain1_wdata", dm_wdata, 32'hBBBB);
`else
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h102);
        #1;
        check("nf_stall_both",  ld_stall, 1);
        check("nf_ld_hit",      ld_hit,   0);
        check("nf_ld_data",     ld_data,  0);
        @(negedge clk);
        #1;
        check("nf_stall_one",   ld_stall, 1);
        check("nf_drain0_write", dm_write, 1);
        check("nf_drain0_wdata", dm_wdata, 32'hAAAA);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h104);
        #1;
        check("nf_other_word_stall", ld_stall, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h102);
        @(negedge clk);
        #1;
        check("nf_stall_drained", ld_stall, 0);
        check("nf_drain1_wdata",  dm_wdata, 32'hBBBB);
`endif
        @(negedge clk);
        #1;
        check("match_done_empty", empty, 1);

        // Port conflict: a load claims the port, drain waits one cycle.
        @(negedge clk);
        drive(1'b1, 32'h300, 32'h33, 1'b0, 32'h800);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h800);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h800);
        #1;
        check("pc_blocked_dm_write", dm_write, 0);
        check("pc_blocked_empty",    empty,    0);
        @(negedge clk);
        #1;
        check("pc_resume_dm_write", dm_write, 1);
        check("pc_resume_dm_addr",  dm_addr,  32'h300);
        check("pc_resume_dm_wdata", dm_wdata, 32'h33);
        @(negedge clk);
        #1;
        check("pc_done_dm_write", dm_write, 0);
        check("pc_done_empty",    empty,    1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
